// File: rtl/turfio_cmdproc_framer.sv
// Frames the command-processor byte stream into length/checksum packets, buffers
// validated payloads and replays them as an AXI4-Stream. Bad packets are dropped whole.
module turfio_cmdproc_framer #(
  parameter int ADDR_BITS = 8,
  parameter int MAX_LEN   = 64
) (
  input  logic        sysclk_i,
  input  logic        sysclk_rstn_i,
  input  logic        cmdproc_rst_i,
  input  logic [7:0]  s_cmd_tdata,
  input  logic        s_cmd_tvalid,
  input  logic        s_cmd_tlast,
  output logic [7:0]  m_pkt_tdata,
  output logic        m_pkt_tvalid,
  output logic        m_pkt_tlast,
  input  logic        m_pkt_tready,
  output logic [15:0] pkt_good_o,
  output logic [15:0] pkt_err_o,
  output logic [15:0] pkt_ovf_o,
  output logic        err_o
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int PW    = ADDR_BITS + 1;

  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, DISCARD} state_t;

  state_t        state_reg, state_next;
  logic [7:0]    sum_reg, sum_next;
  logic [7:0]    cnt_reg, cnt_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] wr_commit_reg, wr_commit_next;
  logic [PW-1:0] rd_ptr_reg;
  logic          out_valid_reg;
  logic          err_reg;
  logic [8:0]    rd_word_reg;
  logic [8:0]    mem [DEPTH];

  logic          flush;
  logic          wr_en;
  logic [8:0]    wr_word;
  logic          good_inc, err_inc, ovf_inc;
  logic          fetch;
  logic [PW-1:0] in_flight, free_space;
  logic [31:0]   len_w, free_w;
  logic          bad_len;
  logic [7:0]    chk_sum;

  assign flush      = !sysclk_rstn_i || cmdproc_rst_i;
  assign in_flight  = wr_ptr_reg - rd_ptr_reg;
  assign free_space = PW'(DEPTH) - in_flight;
  assign len_w      = {24'd0, s_cmd_tdata};
  assign free_w     = 32'(free_space);
  assign bad_len    = (s_cmd_tdata == 8'd0) || (len_w > MAX_LEN);
  assign chk_sum    = sum_reg + s_cmd_tdata;

  always_comb begin
    state_next     = state_reg;
    sum_next       = sum_reg;
    cnt_next       = cnt_reg;
    wr_ptr_next    = wr_ptr_reg;
    wr_commit_next = wr_commit_reg;
    wr_en          = 1'b0;
    wr_word        = {cnt_reg == 8'd1, s_cmd_tdata};
    good_inc       = 1'b0;
    err_inc        = 1'b0;
    ovf_inc        = 1'b0;
    if (s_cmd_tvalid) begin
      case (state_reg)
        IDLE: begin
          sum_next = s_cmd_tdata;
          cnt_next = s_cmd_tdata;
          if (bad_len || s_cmd_tlast) begin
            err_inc    = 1'b1;
            state_next = s_cmd_tlast ? IDLE : DISCARD;
          end else if (len_w > free_w) begin
            ovf_inc    = 1'b1;
            state_next = DISCARD;
          end else begin
            state_next = PAYLOAD;
          end
        end
        PAYLOAD: begin
          wr_en       = 1'b1;
          wr_ptr_next = wr_ptr_reg + 1'b1;
          sum_next    = chk_sum;
          cnt_next    = cnt_reg - 8'd1;
          if (s_cmd_tlast) begin
            err_inc     = 1'b1;
            wr_ptr_next = wr_commit_reg;
            state_next  = IDLE;
          end else if (cnt_reg == 8'd1) begin
            state_next = CHECK;
          end
        end
        CHECK: begin
          if (s_cmd_tlast && chk_sum == 8'h00) begin
            wr_commit_next = wr_ptr_reg;
            good_inc       = 1'b1;
            state_next     = IDLE;
          end else begin
            err_inc     = 1'b1;
            wr_ptr_next = wr_commit_reg;
            state_next  = s_cmd_tlast ? IDLE : DISCARD;
          end
        end
        default: begin
          if (s_cmd_tlast) state_next = IDLE;
        end
      endcase
    end
  end

  // The read register doubles as the output stage, so only fetch when it is free or draining.
  assign fetch = (rd_ptr_reg != wr_commit_reg) && (!out_valid_reg || m_pkt_tready);

  always_ff @(posedge sysclk_i) begin
    if (flush) begin
      state_reg     <= IDLE;
      sum_reg       <= '0;
      cnt_reg       <= '0;
      wr_ptr_reg    <= '0;
      wr_commit_reg <= '0;
      rd_ptr_reg    <= '0;
      out_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sum_reg       <= sum_next;
      cnt_reg       <= cnt_next;
      wr_ptr_reg    <= wr_ptr_next;
      wr_commit_reg <= wr_commit_next;
      err_reg       <= err_inc | ovf_inc;
      if (fetch) begin
        rd_ptr_reg    <= rd_ptr_reg + 1'b1;
        out_valid_reg <= 1'b1;
      end else if (m_pkt_tready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge sysclk_i) begin
    if (wr_en && !flush) mem[wr_ptr_reg[ADDR_BITS-1:0]] <= wr_word;
  end

  always_ff @(posedge sysclk_i) begin
    if (flush) rd_word_reg <= '0;
    else if (fetch) rd_word_reg <= mem[rd_ptr_reg[ADDR_BITS-1:0]];
  end

  // Counters survive a soft flush; only the hard reset clears them.
  logic [2:0]       stat_inc;
  logic [2:0][15:0] stat_q;
  assign stat_inc = {ovf_inc, err_inc, good_inc};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_stat
      logic [15:0] stat_reg;
      always_ff @(posedge sysclk_i) begin
        if (!sysclk_rstn_i) stat_reg <= '0;
        else if (!cmdproc_rst_i && stat_inc[gi] && stat_reg != 16'hFFFF)
          stat_reg <= stat_reg + 16'd1;
      end
      assign stat_q[gi] = stat_reg;
    end
  endgenerate

  assign pkt_good_o   = stat_q[0];
  assign pkt_err_o    = stat_q[1];
  assign pkt_ovf_o    = stat_q[2];
  assign err_o        = err_reg;
  assign m_pkt_tvalid = out_valid_reg;
  assign m_pkt_tdata  = rd_word_reg[7:0];
  assign m_pkt_tlast  = rd_word_reg[8];

endmodule

// File: tb/tb_turfio_cmdproc_framer.sv
// Directed bench: one framer at default size, one small (ADDR_BITS=4) for overflow.
module tb_turfio_cmdproc_framer;

  logic        clk = 1'b0;
  logic        rstn, flush;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tlast, sel_b;
  logic [7:0]  a_data, b_data;
  logic        a_valid, a_last, a_ready, a_erro;
  logic        b_valid, b_last, b_ready, b_erro;
  logic [15:0] a_good, a_perr, a_ovf, b_good, b_perr, b_ovf;

  always #5 clk = ~clk;

  turfio_cmdproc_framer dut_a (
    .sysclk_i(clk), .sysclk_rstn_i(rstn), .cmdproc_rst_i(flush),
    .s_cmd_tdata(s_tdata), .s_cmd_tvalid(s_tvalid & ~sel_b), .s_cmd_tlast(s_tlast),
    .m_pkt_tdata(a_data), .m_pkt_tvalid(a_valid), .m_pkt_tlast(a_last), .m_pkt_tready(a_ready),
    .pkt_good_o(a_good), .pkt_err_o(a_perr), .pkt_ovf_o(a_ovf), .err_o(a_erro)
  );

  turfio_cmdproc_framer #(.ADDR_BITS(4), .MAX_LEN(16)) dut_b (
    .sysclk_i(clk), .sysclk_rstn_i(rstn), .cmdproc_rst_i(flush),
    .s_cmd_tdata(s_tdata), .s_cmd_tvalid(s_tvalid & sel_b), .s_cmd_tlast(s_tlast),
    .m_pkt_tdata(b_data), .m_pkt_tvalid(b_valid), .m_pkt_tlast(b_last), .m_pkt_tready(b_ready),
    .pkt_good_o(b_good), .pkt_err_o(b_perr), .pkt_ovf_o(b_ovf), .err_o(b_erro)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [8:0] qa[$];
  logic [8:0] qb[$];
  logic [7:0] frm[$];
  logic [8:0] exp_a, exp_b, held_a, held_b;
  logic       stall_a = 1'b0, stall_b = 1'b0;
  logic       tog_a = 1'b0;
  int         errs_a = 0, errs_b = 0, outs_b = 0;

  // Output monitors: sample mid-cycle, compare every accepted byte with the scoreboard.
  initial forever begin
    @(negedge clk);
    if (a_erro === 1'b1) errs_a++;
    if (b_erro === 1'b1) errs_b++;
    if (stall_a) begin
      check_val("a_hold_valid", int'(a_valid), 1);
      check_val("a_hold_word", int'({a_last, a_data}), int'(held_a));
    end
    if (stall_b) begin
      check_val("b_hold_valid", int'(b_valid), 1);
      check_val("b_hold_word", int'({b_last, b_data}), int'(held_b));
    end
    stall_a = (a_valid === 1'b1) && !a_ready && !flush && rstn;
    stall_b = (b_valid === 1'b1) && !b_ready && !flush && rstn;
    held_a  = {a_last, a_data};
    held_b  = {b_last, b_data};
    if (a_valid === 1'b1 && a_ready) begin
      if (qa.size() == 0) check_val("a_unexpected_out", int'(a_valid), 0);
      else begin
        exp_a = qa.pop_front();
        check_val("a_data", int'(a_data), int'(exp_a[7:0]));
        check_val("a_last", int'(a_last), int'(exp_a[8]));
      end
    end
    if (b_valid === 1'b1 && b_ready) begin
      outs_b++;
      if (qb.size() == 0) check_val("b_unexpected_out", int'(b_valid), 0);
      else begin
        exp_b = qb.pop_front();
        check_val("b_data", int'(b_data), int'(exp_b[7:0]));
        check_val("b_last", int'(b_last), int'(exp_b[8]));
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (tog_a) a_ready = ~a_ready;
  endtask

  task automatic put(input logic [7:0] b, input logic last);
    s_tdata  = b;
    s_tlast  = last;
    s_tvalid = 1'b1;
    tick();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_frm();
    for (int i = 0; i < frm.size(); i++) put(frm[i], i == frm.size() - 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain_a(input string tag, input int limit);
    int k = 0;
    while (qa.size() != 0 && k < limit) begin tick(); k++; end
    check_val(tag, qa.size(), 0);
  endtask

  int wp_a = 0;
  logic [7:0] s, pb;

  initial begin
    rstn = 1'b0; flush = 1'b0; s_tdata = 8'h00; s_tvalid = 1'b0; s_tlast = 1'b0;
    sel_b = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
    idle(3);
    check_val("rst_a_valid", int'(a_valid), 0);
    check_val("rst_a_data", int'(a_data), 0);
    check_val("rst_a_last", int'(a_last), 0);
    check_val("rst_a_good", int'(a_good), 0);
    check_val("rst_a_perr", int'(a_perr), 0);
    check_val("rst_a_ovf", int'(a_ovf), 0);
    check_val("rst_a_err", int'(a_erro), 0);
    check_val("rst_b_valid", int'(b_valid), 0);
    rstn = 1'b1;
    idle(2);

    // Good frame; checksum makes the byte sum 0x00.
    frm = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    qa.push_back(9'h011); qa.push_back(9'h022); qa.push_back(9'h133);
    send_frm();
    check_val("t1_valid_after_k", int'(a_valid), 0);
    tick();
    check_val("t1_valid_after_k1", int'(a_valid), 1);
    check_val("t1_first_byte", int'(a_data), 8'h11);
    idle(5);
    wp_a = 3;
    check_val("t1_good", int'(a_good), 1);
    check_val("t1_no_err", errs_a, 0);
    check_val("t1_wr_ptr", int'(dut_a.wr_ptr_reg), wp_a);

    // Bad checksum, then a good frame.
    frm = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h98};
    send_frm();
    check_val("t2_err_pulse", int'(a_erro), 1);
    tick();
    check_val("t2_err_drop", int'(a_erro), 0);
    idle(3);
    check_val("t2_err_count", errs_a, 1);
    check_val("t2_perr", int'(a_perr), 1);
    check_val("t2_wr_ptr", int'(dut_a.wr_ptr_reg), wp_a);
    check_val("t2_no_out", int'(a_valid), 0);
    frm = '{8'h02, 8'hAA, 8'h55, 8'hFF};
    qa.push_back(9'h0AA); qa.push_back(9'h155);
    send_frm();
    idle(6);
    wp_a = 5;
    check_val("t2_good", int'(a_good), 2);
    check_val("t2_wr_ptr_after", int'(dut_a.wr_ptr_reg), wp_a);

    // Length zero, over-length, and early tlast inside the payload.
    frm = '{8'h00, 8'h01, 8'h02};
    send_frm(); idle(2);
    check_val("t3_l0_wr_ptr", int'(dut_a.wr_ptr_reg), wp_a);
    frm = '{8'h41, 8'h01, 8'h02, 8'h03};
    send_frm(); idle(2);
    check_val("t3_l65_wr_ptr", int'(dut_a.wr_ptr_reg), wp_a);
    put(8'h04, 1'b0); put(8'h01, 1'b0);
    check_val("t3_l4_mid_wr_ptr", int'(dut_a.wr_ptr_reg), wp_a + 1);
    put(8'h02, 1'b1); idle(2);
    check_val("t3_l4_wr_ptr", int'(dut_a.wr_ptr_reg), wp_a);
    idle(2);
    check_val("t3_perr", int'(a_perr), 4);
    check_val("t3_err_count", errs_a, 4);
    check_val("t3_ovf", int'(a_ovf), 0);
    check_val("t3_no_out", int'(a_valid), 0);

    // Overflow on the 16-entry instance with the output stalled.
    sel_b = 1'b1; b_ready = 1'b0;
    frm = '{8'h0A}; s = 8'h0A;
    for (int j = 1; j <= 10; j++) begin
      frm.push_back(8'(j)); s = s + 8'(j);
      qb.push_back({j == 10, 8'(j)});
    end
    frm.push_back(8'h00 - s);
    send_frm(); idle(3);
    frm = '{8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hD4};
    send_frm(); idle(2);
    check_val("t4_ovf", int'(b_ovf), 1);
    check_val("t4_err_pulses", errs_b, 1);
    check_val("t4_perr", int'(b_perr), 0);
    check_val("t4_good", int'(b_good), 1);
    check_val("t4_out_before", outs_b, 0);
    sel_b = 1'b0; b_ready = 1'b1;
    idle(20);
    check_val("t4_out_count", outs_b, 10);
    check_val("t4_left", qb.size(), 0);
    check_val("t4_idle_valid", int'(b_valid), 0);

    // Back-to-back L=7 frames with tready toggling; the write address wraps.
    tog_a = 1'b1;
    for (int f = 0; f < 40; f++) begin
      frm = '{8'h07}; s = 8'h07;
      for (int j = 0; j < 7; j++) begin
        pb = 8'(f * 7 + j * 13 + 5);
        frm.push_back(pb); s = s + pb;
        qa.push_back({j == 6, pb});
      end
      frm.push_back(8'h00 - s);
      send_frm();
    end
    drain_a("t5_drain_left", 2000);
    tog_a = 1'b0; a_ready = 1'b1;
    idle(3);
    wp_a = wp_a + 280;
    check_val("t5_good", int'(a_good), 42);
    check_val("t5_perr", int'(a_perr), 4);
    check_val("t5_ovf", int'(a_ovf), 0);
    check_val("t5_wr_ptr", int'(dut_a.wr_ptr_reg), wp_a);
    check_val("t5_idle_valid", int'(a_valid), 0);

    // Soft flush mid-payload with committed data pending; flush beats the byte.
    a_ready = 1'b0;
    frm = '{8'h02, 8'h5A, 8'hA5, 8'hFF};
    send_frm(); idle(3);
    check_val("t6_pending", int'(a_valid), 1);
    put(8'h05, 1'b0); put(8'h01, 1'b0); put(8'h02, 1'b0);
    flush = 1'b1; s_tdata = 8'h03; s_tvalid = 1'b1;
    tick();
    flush = 1'b0; s_tvalid = 1'b0;
    wp_a = 0;
    check_val("t6_valid_cleared", int'(a_valid), 0);
    check_val("t6_good_held", int'(a_good), 43);
    check_val("t6_perr_held", int'(a_perr), 4);
    check_val("t6_ovf_held", int'(a_ovf), 0);
    check_val("t6_wr_ptr", int'(dut_a.wr_ptr_reg), wp_a);
    a_ready = 1'b1;
    idle(2);
    check_val("t6_still_empty", int'(a_valid), 0);
    frm = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    qa.push_back(9'h011); qa.push_back(9'h022); qa.push_back(9'h133);
    send_frm();
    drain_a("t6_drain_left", 50);
    idle(2);
    check_val("t6_good_after", int'(a_good), 44);
    check_val("t6_wr_ptr_after", int'(dut_a.wr_ptr_reg), 3);
    check_val("t6_err_count", errs_a, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
